// File: rtl/ram_bist_ctrl.sv
// Purpose: march-free write-then-verify BIST sequencer for a single-port RAM with combinational read.
// Latency: first write the cycle after start; DEPTH write + 2*DEPTH read cycles, done pulses the cycle after.
// Backpressure: none; the RAM takes one access per cycle, abort returns to idle on the next edge.
module ram_bist_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int PAT_MUL = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write,
    output logic              ram_select,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WRITE   = 3'd1;
    localparam logic [2:0] S_RD_ADDR = 3'd2;
    localparam logic [2:0] S_RD_CHK  = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic [2:0]        state;
    logic [ADDR_W-1:0] next_addr;
    logic              mismatch;

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
        return DATA_W'(32'(a) * 32'(PAT_MUL));
    endfunction

    assign next_addr = ram_address + 1'b1;
    // ram_data_in keeps the expected value of the current address during reads
    assign mismatch  = (ram_data_out != ram_data_in);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            ram_address    <= '0;
            ram_data_in    <= '0;
            ram_write      <= 1'b0;
            ram_select     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (busy && abort) begin
            state      <= S_IDLE;
            ram_write  <= 1'b0;
            ram_select <= 1'b0;
            busy       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state          <= S_WRITE;
                        ram_address    <= '0;
                        ram_data_in    <= pattern('0);
                        ram_write      <= 1'b1;
                        ram_select     <= 1'b1;
                        busy           <= 1'b1;
                        pass           <= 1'b0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                    end
                end
                S_WRITE: begin
                    if (ram_address == LAST_ADDR) begin
                        state       <= S_RD_ADDR;
                        ram_write   <= 1'b0;
                        ram_address <= '0;
                        ram_data_in <= pattern('0);
                    end else begin
                        ram_address <= next_addr;
                        ram_data_in <= pattern(next_addr);
                    end
                end
                S_RD_ADDR: begin
                    state <= S_RD_CHK;
                end
                S_RD_CHK: begin
                    if (mismatch) begin
                        err_count <= err_count + 1'b1;
                        if (err_count == '0) begin
                            first_err_addr <= ram_address;
                        end
                    end
                    if (ram_address == LAST_ADDR) begin
                        state      <= S_DONE;
                        ram_select <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        pass       <= (err_count == '0) && !mismatch;
                    end else begin
                        state       <= S_RD_ADDR;
                        ram_address <= next_addr;
                        ram_data_in <= pattern(next_addr);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: faultable RAM model, cycle-index reference model, directed scenarios.
module tb_ram_bist_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  ram_data_out;
    logic [9:0]  ram_address;
    logic [7:0]  ram_data_in;
    logic        ram_write;
    logic        ram_select;
    logic        busy;
    logic        done;
    logic        pass;
    logic [10:0] err_count;
    logic [9:0]  first_err_addr;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    int fault_mode = 0;
    int fa0 = 2000;
    int fa1 = 2000;

    ram_bist_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .ram_data_out   (ram_data_out),
        .ram_address    (ram_address),
        .ram_data_in    (ram_data_in),
        .ram_write      (ram_write),
        .ram_select     (ram_select),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    always #5 clk = ~clk;

    // RAM: synchronous write, combinational read with injectable read faults
    logic [7:0] mem [0:1023];
    logic [7:0] raw;
    always @(posedge clk) if (ram_select && ram_write) mem[ram_address] <= ram_data_in;
    assign raw = mem[ram_address];
    assign ram_data_out = (fault_mode == 2) ? 8'hFF :
                          ((fault_mode == 1) && (int'(ram_address) == fa0 || int'(ram_address) == fa1)) ?
                          (raw | 8'h01) : raw;

    function automatic int expv(input int a);
        return (a * 2) % 256;
    endfunction

    function automatic bit bad_read(input int a, input int mode, input int f0, input int f1);
        int rd;
        rd = expv(a);
        if (mode == 2) rd = 255;
        else if (mode == 1 && (a == f0 || a == f1)) rd = rd | 1;
        return rd != expv(a);
    endfunction

    // Reference model: m_t is the 1-based cycle index within a test (0 = idle).
    // 1..1024 write addr t-1; 1025..3072 alternate address/check; 3073 done.
    int m_t = 0;
    int m_err = 0;
    int m_first = 0;
    bit m_pass = 1'b0;

    always @(posedge clk) begin : model
        int t_n, err_n, first_n, a;
        bit pass_n;
        t_n = m_t; err_n = m_err; first_n = m_first; pass_n = m_pass;
        if (reset) begin
            t_n = 0; err_n = 0; first_n = 0; pass_n = 1'b0;
        end else if (m_t == 0) begin
            if (start) begin
                t_n = 1; err_n = 0; first_n = 0; pass_n = 1'b0;
            end
        end else if (m_t == 3073) begin
            t_n = 0;
        end else if (abort) begin
            t_n = 0; pass_n = 1'b0;
        end else begin
            if (m_t >= 1025 && ((m_t - 1025) % 2 == 1)) begin
                a = (m_t - 1025) / 2;
                if (bad_read(a, fault_mode, fa0, fa1)) begin
                    if (err_n == 0) first_n = a;
                    err_n = err_n + 1;
                end
            end
            t_n = m_t + 1;
            if (t_n == 3073) pass_n = (err_n == 0);
        end
        m_t     <= t_n;
        m_err   <= err_n;
        m_first <= first_n;
        m_pass  <= pass_n;
    end

    always @(negedge clk) begin : compare
        bit e_busy, e_wr, bad;
        int e_addr;
        if (chk_en) begin
            e_busy = (m_t >= 1 && m_t <= 3072);
            e_wr   = (m_t >= 1 && m_t <= 1024);
            e_addr = e_wr ? m_t - 1 : (m_t - 1025) / 2;
            bad = (busy !== e_busy) || (ram_select !== e_busy) || (ram_write !== e_wr) ||
                  (done !== (m_t == 3073)) || (pass !== m_pass) ||
                  (int'(err_count) != m_err) || (int'(first_err_addr) != m_first) ||
                  (e_busy && int'(ram_address) != e_addr) ||
                  (e_wr && int'(ram_data_in) != expv(e_addr));
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL cycle_model t=%0d got busy=%b sel=%b wr=%b done=%b pass=%b err=%0d first=%0d addr=%0d din=%0d expected busy=%b wr=%b done=%b pass=%b err=%0d first=%0d addr=%0d",
                         m_t, busy, ram_select, ram_write, done, pass, err_count, first_err_addr,
                         ram_address, ram_data_in, e_busy, e_wr, (m_t == 3073), m_pass, m_err, m_first, e_addr);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        adv(1);
        start = 1'b0;
    endtask

    // Returns the 1-based cycle index of the done pulse, or -1 on timeout.
    task automatic wait_done(output int cyc);
        int n;
        n = 0;
        while (!done && n < 4000) begin
            adv(1);
            n++;
        end
        cyc = done ? n + 1 : -1;
    endtask

    task automatic run_and_check(input string tag, input int e_err, input int e_first, input int e_pass);
        int c;
        pulse_start();
        wait_done(c);
        check({tag, "_done_cycle"}, c, 3073);
        check({tag, "_err_count"}, int'(err_count), e_err);
        check({tag, "_first_err"}, int'(first_err_addr), e_first);
        check({tag, "_pass"}, int'(pass), e_pass);
        adv(1);
        check({tag, "_done_one_cycle"}, int'(done), 0);
        adv(2);
    endtask

    initial begin
        int c, done_seen;
        adv(1);
        chk_en = 1'b1;
        adv(2);
        check("reset_outputs", int'({busy, done, pass, ram_select, ram_write, err_count, first_err_addr, ram_address, ram_data_in}), 0);
        reset = 1'b0;
        adv(2);

        // ideal RAM
        fault_mode = 0;
        run_and_check("ideal", 0, 0, 1);

        // single stuck bit at address 5
        fault_mode = 1; fa0 = 5; fa1 = 2000;
        run_and_check("stuck5", 1, 5, 0);

        // stuck bits at 5 and 700
        fa0 = 5; fa1 = 700;
        run_and_check("stuck5_700", 2, 5, 0);

        // every read returns 0xFF; the pattern is always even
        fault_mode = 2; fa0 = 2000; fa1 = 2000;
        run_and_check("all_ff", 1024, 0, 0);

        // abort during write of address 100, then rerun
        fault_mode = 0;
        pulse_start();
        adv(100);
        check("abort_pre_addr", int'(ram_address), 100);
        check("abort_pre_wr", int'(ram_write), 1);
        abort = 1'b1;
        adv(1);
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_sel", int'(ram_select), 0);
        check("abort_wr", int'(ram_write), 0);
        check("abort_pass", int'(pass), 0);
        done_seen = 0;
        for (int i = 0; i < 3100; i++) begin
            if (done) done_seen++;
            adv(1);
        end
        check("abort_no_done", done_seen, 0);
        run_and_check("after_abort", 0, 0, 1);

        // reset while checking address 300 with partial errors accumulated
        fault_mode = 2;
        pulse_start();
        adv(1625);
        check("rst_pre_addr", int'(ram_address), 300);
        check("rst_pre_err", int'(err_count), 300);
        check("rst_pre_rd", int'({ram_select, ram_write}), 2);
        reset = 1'b1;
        adv(1);
        reset = 1'b0;
        check("rst_mid_outputs", int'({busy, done, pass, ram_select, ram_write, err_count, first_err_addr, ram_address, ram_data_in}), 0);
        adv(3);

        // start re-pulsed while busy must be ignored
        fault_mode = 0;
        pulse_start();
        adv(500);
        start = 1'b1;
        adv(1);
        start = 1'b0;
        wait_done(c);
        check("restart_done_cycle", (c < 0) ? -1 : c + 501, 3073);
        check("restart_pass", int'(pass), 1);
        check("restart_err", int'(err_count), 0);
        adv(3);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
